// File: rtl/gcn_controller_if.sv
// GCN controller bus: host control, stage start/done handshakes, class results and output-memory writes.
// Latency: none, wiring only.
// Backpressure: none; the stage done inputs are the only flow control and the controller waits on them.
//
// Ports (signals carried by the bundle):
//   start, clear_err          host requests into the controller
//   trans_/agg_/max_start     one-cycle stage kick pulses out of the controller
//   trans_/agg_/max_done      stage completion inputs (level or pulse)
//   class_in                  packed arg-max results, node i at [i*CLS_W +: CLS_W]
//   out_we/out_addr/out_data  output-memory write port
//   busy/done/error/stage     status
// The master modport is the controller's view; slave is the datapath/host view.
interface gcn_controller_if #(
    parameter int NUM_NODES = 6,
    parameter int CLS_W     = 2,
    parameter int ADDR_W    = 3
);
    logic                       start;
    logic                       clear_err;
    logic                       trans_start;
    logic                       trans_done;
    logic                       agg_start;
    logic                       agg_done;
    logic                       max_start;
    logic                       max_done;
    logic [NUM_NODES*CLS_W-1:0] class_in;
    logic                       out_we;
    logic [ADDR_W-1:0]          out_addr;
    logic [CLS_W-1:0]           out_data;
    logic                       busy;
    logic                       done;
    logic                       error;
    logic [2:0]                 stage;

    modport master (
        input  start, clear_err, trans_done, agg_done, max_done, class_in,
        output trans_start, agg_start, max_start,
        output out_we, out_addr, out_data,
        output busy, done, error, stage
    );

    modport slave (
        output start, clear_err, trans_done, agg_done, max_done, class_in,
        input  trans_start, agg_start, max_start,
        input  out_we, out_addr, out_data,
        input  busy, done, error, stage
    );
endinterface

// File: rtl/gcn_controller.sv
// Sequences one GCN inference: transform -> aggregate -> arg-max, then streams NUM_NODES classes to memory.
// Latency: start to done is 1 + 3*(d+1) + NUM_NODES + 1 cycles when each stage finishes d cycles after its kick.
// Backpressure: waits indefinitely-bounded (TIMEOUT) on each stage done input; start is dropped while busy.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset; forces IDLE and zeroes every output
//   bus    gcn_controller_if.master bundle (stage handshakes, class results, write port, status)
module gcn_controller #(
    parameter int NUM_NODES = 6,
    parameter int CLS_W     = 2,
    parameter int TIMEOUT   = 255,
    parameter int ADDR_W    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    gcn_controller_if.master bus
);

    // Encoding is visible on the stage output, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRANS = 3'd1,
        ST_AGG   = 3'd2,
        ST_MAX   = 3'd3,
        ST_WRITE = 3'd4,
        ST_FIN   = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam int                CLS_BITS  = NUM_NODES * CLS_W;
    localparam logic [8:0]        TMO_LIM   = 9'(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NODES - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [CLS_BITS-1:0] cls_q, cls_d;
    logic                trans_start_q, trans_start_d;
    logic                agg_start_q, agg_start_d;
    logic                max_start_q, max_start_d;
    logic                done_q, done_d;
    logic                out_we_q, out_we_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [CLS_W-1:0]    out_data_q, out_data_d;

    logic                stage_done;
    logic                stage_first;
    logic                stage_tmo;
    logic [8:0]          cnt_inc;

    // Done input of the stage we are currently in; other stages' done lines are ignored.
    always_comb begin
        stage_done = 1'b0;
        case (state_q)
            ST_TRANS: stage_done = bus.trans_done;
            ST_AGG:   stage_done = bus.agg_done;
            ST_MAX:   stage_done = bus.max_done;
            default:  stage_done = 1'b0;
        endcase
    end

    // The counter is zero exactly in the cycle the stage's start pulse is high, so a done
    // level left over from before the kick cannot be mistaken for completion.
    assign stage_first = (cnt_q == 8'd0);
    assign cnt_inc     = {1'b0, cnt_q} + 9'd1;
    // Fires in the stage's TIMEOUT-th cycle, so ERR is entered TIMEOUT cycles after the kick.
    assign stage_tmo   = (cnt_inc == TMO_LIM);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cls_d         = cls_q;
        trans_start_d = 1'b0;
        agg_start_d   = 1'b0;
        max_start_d   = 1'b0;
        done_d        = 1'b0;
        out_we_d      = 1'b0;
        out_addr_d    = '0;
        out_data_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d       = ST_TRANS;
                    trans_start_d = 1'b1;
                    cnt_d         = 8'd0;
                end
            end

            ST_TRANS, ST_AGG, ST_MAX: begin
                cnt_d = cnt_inc[7:0];
                // Done is checked before timeout: a completion in the last allowed cycle wins.
                if (stage_done && !stage_first) begin
                    cnt_d = 8'd0;
                    case (state_q)
                        ST_TRANS: begin
                            state_d     = ST_AGG;
                            agg_start_d = 1'b1;
                        end
                        ST_AGG: begin
                            state_d     = ST_MAX;
                            max_start_d = 1'b1;
                        end
                        default: begin
                            // Snapshot the arg-max results; node 0 goes out now and the rest
                            // are kept pre-shifted so node k is always in the low slot.
                            state_d    = ST_WRITE;
                            cls_d      = bus.class_in >> CLS_W;
                            out_we_d   = 1'b1;
                            out_addr_d = '0;
                            out_data_d = bus.class_in[CLS_W-1:0];
                        end
                    endcase
                end else if (stage_tmo) begin
                    state_d = ST_ERR;
                    cnt_d   = 8'd0;
                end
            end

            ST_WRITE: begin
                if (out_addr_q == LAST_ADDR) begin
                    state_d = ST_FIN;
                    cls_d   = '0;
                end else begin
                    out_we_d   = 1'b1;
                    out_addr_d = out_addr_q + 1'b1;
                    out_data_d = cls_q[CLS_W-1:0];
                    cls_d      = cls_q >> CLS_W;
                end
            end

            // done is registered out of FIN, so the pulse lands in the first IDLE cycle after it.
            ST_FIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end

            ST_ERR: begin
                if (bus.clear_err) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            cls_q         <= '0;
            trans_start_q <= 1'b0;
            agg_start_q   <= 1'b0;
            max_start_q   <= 1'b0;
            done_q        <= 1'b0;
            out_we_q      <= 1'b0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cls_q         <= cls_d;
            trans_start_q <= trans_start_d;
            agg_start_q   <= agg_start_d;
            max_start_q   <= max_start_d;
            done_q        <= done_d;
            out_we_q      <= out_we_d;
            out_addr_q    <= out_addr_d;
            out_data_q    <= out_data_d;
        end
    end

    assign bus.trans_start = trans_start_q;
    assign bus.agg_start   = agg_start_q;
    assign bus.max_start   = max_start_q;
    assign bus.out_we      = out_we_q;
    assign bus.out_addr    = out_addr_q;
    assign bus.out_data    = out_data_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.error       = (state_q == ST_ERR);
    assign bus.stage       = state_q;

endmodule

// File: tb/tb_gcn_controller.sv
// Bench for gcn_controller: directed per-cycle stimulus table, timeline model, per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_gcn_controller;

    localparam int NN  = 6;
    localparam int CW  = 2;
    localparam int AW  = 3;
    localparam int TMO = 4;
    localparam int CB  = NN * CW;
    localparam int LEN = 128;
    localparam int RST_CYC = 95;

    typedef struct packed {
        logic [2:0]    stage;
        logic          busy;
        logic          error;
        logic          done;
        logic          ts;
        logic          as;
        logic          ms;
        logic          we;
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } obs_t;

    typedef struct packed {
        logic          start;
        logic          clr;
        logic          td;
        logic          ad;
        logic          md;
        logic [CB-1:0] cls;
    } stim_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;

    obs_t  exp_tab  [LEN];
    obs_t  got_tab  [LEN];
    stim_t stim_tab [LEN];

    gcn_controller_if #(.NUM_NODES(NN), .CLS_W(CW), .ADDR_W(AW)) bus_if ();

    gcn_controller #(.NUM_NODES(NN), .CLS_W(CW), .TIMEOUT(TMO), .ADDR_W(AW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CB-1:0] pack6(input int n0, input int n1, input int n2,
                                            input int n3, input int n4, input int n5);
        logic [CB-1:0] v;
        v = '0;
        v[0*CW +: CW] = CW'(n0);
        v[1*CW +: CW] = CW'(n1);
        v[2*CW +: CW] = CW'(n2);
        v[3*CW +: CW] = CW'(n3);
        v[4*CW +: CW] = CW'(n4);
        v[5*CW +: CW] = CW'(n5);
        return v;
    endfunction

    task automatic chk(input string name, input int got_v, input int want_v);
        n_chk = n_chk + 1;
        if (got_v == want_v) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, want %0d", name, got_v, want_v);
    endtask

    task automatic mark(input int c, input int st);
        exp_tab[c].stage = 3'(st);
        exp_tab[c].busy  = (st != 0);
        exp_tab[c].error = (st == 6);
    endtask

    // Inference timeline: each stage lasts (delay + 1) cycles after its kick, WRITE lasts NN,
    // FIN one cycle, and done shows in the cycle after FIN. Class results are only valid on the
    // max_done cycle; every other cycle carries their bitwise complement as poison.
    task automatic plan_run(input int c0, input int dt, input int da, input int dm,
                            input logic [CB-1:0] cls);
        int t1, a1, m1, w1, f;
        t1 = c0 + 1;
        a1 = t1 + dt + 1;
        m1 = a1 + da + 1;
        w1 = m1 + dm + 1;
        f  = w1 + NN;
        stim_tab[c0].start = 1'b1;
        stim_tab[t1 + dt].td = 1'b1;
        stim_tab[a1 + da].ad = 1'b1;
        stim_tab[m1 + dm].md = 1'b1;
        for (int c = c0; c <= f + 1; c++) stim_tab[c].cls = ~cls;
        stim_tab[m1 + dm].cls = cls;
        for (int c = t1; c < a1; c++) mark(c, 1);
        for (int c = a1; c < m1; c++) mark(c, 2);
        for (int c = m1; c < w1; c++) mark(c, 3);
        for (int k = 0; k < NN; k++) begin
            mark(w1 + k, 4);
            exp_tab[w1 + k].we   = 1'b1;
            exp_tab[w1 + k].addr = AW'(k);
            exp_tab[w1 + k].data = cls[k*CW +: CW];
        end
        mark(f, 5);
        exp_tab[t1].ts    = 1'b1;
        exp_tab[a1].as    = 1'b1;
        exp_tab[m1].ms    = 1'b1;
        exp_tab[f + 1].done = 1'b1;
    endtask

    // agg_done never arrives: AGG lasts TMO cycles, then ERR until the clear_err cycle.
    task automatic plan_tmo(input int c0, input int dt, input int clr);
        int t1, a1;
        t1 = c0 + 1;
        a1 = t1 + dt + 1;
        stim_tab[c0].start = 1'b1;
        stim_tab[t1 + dt].td = 1'b1;
        stim_tab[clr].clr = 1'b1;
        for (int c = t1; c < a1; c++) mark(c, 1);
        for (int c = a1; c < a1 + TMO; c++) mark(c, 2);
        for (int c = a1 + TMO; c <= clr; c++) mark(c, 6);
        exp_tab[t1].ts = 1'b1;
        exp_tab[a1].as = 1'b1;
    endtask

    function automatic logic sel_bit(input obs_t o, input int s);
        case (s)
            0:       return o.done;
            1:       return o.ts;
            2:       return o.as;
            3:       return o.ms;
            default: return o.error;
        endcase
    endfunction

    function automatic int first_hit(input int lo, input int hi, input int s);
        for (int c = lo; c <= hi; c++) if (sel_bit(got_tab[c], s)) return c;
        return -1000;
    endfunction

    function automatic int count_hit(input int lo, input int hi, input int s);
        int n;
        n = 0;
        for (int c = lo; c <= hi; c++) if (sel_bit(got_tab[c], s)) n++;
        return n;
    endfunction

    initial begin : main
        obs_t o;
        int   lit1 [NN];
        int   multi;
        lit1 = '{0, 1, 2, 0, 1, 2};
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        bus_if.start      = 1'b0;
        bus_if.clear_err  = 1'b0;
        bus_if.trans_done = 1'b0;
        bus_if.agg_done   = 1'b0;
        bus_if.max_done   = 1'b0;
        bus_if.class_in   = '0;
        for (int c = 0; c < LEN; c++) begin
            exp_tab[c]  = '0;
            got_tab[c]  = '0;
            stim_tab[c] = '0;
        end

        // Run 1: d=3 everywhere (done coincides with timeout in every stage), start right after reset.
        plan_run(1, 3, 3, 3, pack6(0, 1, 2, 0, 1, 2));
        // Run 2: trans_done held high from two cycles before start, through AGG.
        plan_run(25, 1, 1, 2, pack6(2, 2, 1, 0, 1, 0));
        for (int c = 23; c <= 30; c++) stim_tab[c].td = 1'b1;
        // Run 3: extra starts in AGG, WRITE and FIN.
        plan_run(44, 2, 3, 1, pack6(1, 0, 2, 2, 0, 1));
        stim_tab[49].start = 1'b1;
        stim_tab[55].start = 1'b1;
        stim_tab[60].start = 1'b1;
        // Run 4: aggregation never completes; start and a stray agg_done while in ERR.
        plan_tmo(66, 3, 80);
        stim_tab[77].start = 1'b1;
        stim_tab[78].ad    = 1'b1;
        // Run 5: reset lands while address 3 is on the write port; run 6 starts immediately after.
        plan_run(85, 1, 1, 1, pack6(2, 1, 0, 1, 2, 0));
        for (int c = RST_CYC; c <= 99; c++) exp_tab[c] = '0;
        plan_run(96, 3, 2, 3, pack6(0, 2, 1, 1, 0, 2));

        #1;
        chk("reset_stage", int'(bus_if.stage), 0);
        chk("reset_busy_err_done_we",
            int'({bus_if.busy, bus_if.error, bus_if.done, bus_if.out_we}), 0);

        for (int i = 1; i < LEN; i++) begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            bus_if.start      = stim_tab[cyc].start;
            bus_if.clear_err  = stim_tab[cyc].clr;
            bus_if.trans_done = stim_tab[cyc].td;
            bus_if.agg_done   = stim_tab[cyc].ad;
            bus_if.max_done   = stim_tab[cyc].md;
            bus_if.class_in   = stim_tab[cyc].cls;
            if (cyc == 1) rst_n = 1'b1;
            if (cyc == RST_CYC) begin
                #1;
                chk("pre_rst_we", int'(bus_if.out_we), 1);
                chk("pre_rst_addr", int'(bus_if.out_addr), 3);
                rst_n = 1'b0;
                #1;
                chk("async_rst_we", int'(bus_if.out_we), 0);
                chk("async_rst_stage", int'(bus_if.stage), 0);
                chk("async_rst_busy", int'(bus_if.busy), 0);
            end
            if (cyc == RST_CYC + 1) begin
                #1;
                rst_n = 1'b1;
            end
            @(negedge clk);
            o.stage = bus_if.stage;
            o.busy  = bus_if.busy;
            o.error = bus_if.error;
            o.done  = bus_if.done;
            o.ts    = bus_if.trans_start;
            o.as    = bus_if.agg_start;
            o.ms    = bus_if.max_start;
            o.we    = bus_if.out_we;
            o.addr  = bus_if.out_addr;
            o.data  = bus_if.out_data;
            got_tab[cyc] = o;
            n_chk = n_chk + 1;
            if (o == exp_tab[cyc]) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL cycle %0d: got stage=%0d busy=%0d err=%0d done=%0d ts/as/ms=%0d%0d%0d we=%0d addr=%0d data=%0d, want stage=%0d busy=%0d err=%0d done=%0d ts/as/ms=%0d%0d%0d we=%0d addr=%0d data=%0d",
                         cyc, o.stage, o.busy, o.error, o.done, o.ts, o.as, o.ms, o.we, o.addr, o.data,
                         exp_tab[cyc].stage, exp_tab[cyc].busy, exp_tab[cyc].error, exp_tab[cyc].done,
                         exp_tab[cyc].ts, exp_tab[cyc].as, exp_tab[cyc].ms, exp_tab[cyc].we,
                         exp_tab[cyc].addr, exp_tab[cyc].data);
            end
        end

        // Hand-computed expectations that pin the timeline model.
        chk("run1_latency", first_hit(1, 30, 0) - 1, 20);
        for (int k = 0; k < NN; k++) begin
            chk("run1_wr_we",   int'(got_tab[14 + k].we), 1);
            chk("run1_wr_addr", int'(got_tab[14 + k].addr), k);
            chk("run1_wr_data", int'(got_tab[14 + k].data), lit1[k]);
        end
        chk("held_td_gap", first_hit(22, 44, 2) - first_hit(22, 44, 1), 2);
        chk("run3_trans_starts", count_hit(44, 64, 1), 1);
        chk("run3_done_pulses", count_hit(44, 64, 0), 1);
        chk("tmo_err_gap", first_hit(66, 84, 4) - first_hit(66, 84, 2), 4);
        chk("tmo_no_max_start", count_hit(66, 84, 3), 0);
        chk("tmo_err_stage", int'(got_tab[80].stage), 6);
        chk("clr_err_idle", int'(got_tab[81].stage), 0);
        chk("run6_latency", first_hit(96, 120, 0) - 96, 19);
        multi = 0;
        for (int c = 1; c < LEN; c++)
            if (int'(got_tab[c].ts) + int'(got_tab[c].as) + int'(got_tab[c].ms) > 1) multi++;
        chk("start_onehot", multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
